// File: rtl/dma_arbiter_if.sv
// dma_arbiter_if: CPU port, interface-bus port and done interrupt of the DMA arbiter
interface dma_arbiter_if;
  logic [15:0] cpu_address;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic cpu_w_en;
  logic cpu_r_en;
  logic cpu_stall;
  logic [15:0] bus_address;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;
  logic bus_w_en;
  logic bus_r_en;
  logic done_flag;
  logic done_flag_clr;
  modport master (
    output cpu_address, cpu_din, cpu_w_en, cpu_r_en, bus_dout, done_flag_clr,
    input cpu_dout, cpu_stall, bus_address, bus_din, bus_w_en, bus_r_en, done_flag
  );
  modport slave (
    input cpu_address, cpu_din, cpu_w_en, cpu_r_en, bus_dout, done_flag_clr,
    output cpu_dout, cpu_stall, bus_address, bus_din, bus_w_en, bus_r_en, done_flag
  );
endinterface

// File: rtl/dma_arbiter.sv
// dma_arbiter: memory-to-memory DMA sharing the interface bus with the CPU via round-robin
module dma_arbiter #(
  parameter logic [7:0] DMA_ADDRESS = 8'h0C
) (
  input logic clk,
  input logic rst,
  dma_arbiter_if.slave io
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  logic [1:0] state;
  logic [15:0] src, dst;
  logic [7:0] len, data_buf, rdata, off, reg_mux;
  logic cap, abort_pend, last_dma, rd_q, done;
  logic hit, busy, cpu_req, cpu_gnt, dma_gnt, reg_wr, ctrl_wr, abort_now;
  assign off = io.cpu_address[7:0] - DMA_ADDRESS;
  assign hit = io.cpu_address[15:8] == 8'h10 && off < 8'd6;
  assign busy = state != IDLE;
  assign cpu_req = (io.cpu_w_en | io.cpu_r_en) & ~hit;
  assign cpu_gnt = cpu_req & (~busy | last_dma);
  assign dma_gnt = busy & (~cpu_req | ~last_dma);
  assign reg_wr = hit & io.cpu_w_en;
  assign ctrl_wr = reg_wr && off == 8'd5;
  assign abort_now = abort_pend | (ctrl_wr & io.cpu_din[1]);
  assign reg_mux = off == 8'd0 ? src[7:0] : off == 8'd1 ? src[15:8] : off == 8'd2 ? dst[7:0] :
                   off == 8'd3 ? dst[15:8] : off == 8'd4 ? len : {6'b0, done, busy};
  assign io.cpu_stall = cpu_req & ~cpu_gnt;
  assign io.bus_address = cpu_gnt ? io.cpu_address : dma_gnt ? (state == READ ? src : dst) : 16'h0;
  // the first WRITE cycle forwards read data straight through; later ones replay the buffer
  assign io.bus_din = cpu_gnt ? io.cpu_din : (dma_gnt && state == WRITE) ? (cap ? io.bus_dout : data_buf) : 8'h0;
  assign io.bus_w_en = (cpu_gnt & io.cpu_w_en) | (dma_gnt && state == WRITE);
  assign io.bus_r_en = (cpu_gnt & io.cpu_r_en) | (dma_gnt && state == READ);
  assign io.cpu_dout = rd_q ? rdata : io.bus_dout;
  assign io.done_flag = done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      len <= '0;
      data_buf <= '0;
      rdata <= '0;
      cap <= 1'b0;
      abort_pend <= 1'b0;
      last_dma <= 1'b0;
      rd_q <= 1'b0;
      done <= 1'b0;
    end else begin
      rd_q <= hit & io.cpu_r_en;
      rdata <= reg_mux;
      cap <= 1'b0;
      if (cpu_req & busy) last_dma <= dma_gnt;
      if (cap) data_buf <= io.bus_dout;
      if (io.done_flag_clr) done <= 1'b0;
      if (state == IDLE) begin
        abort_pend <= 1'b0;
        if (reg_wr && off == 8'd0) src[7:0] <= io.cpu_din;
        if (reg_wr && off == 8'd1) src[15:8] <= io.cpu_din;
        if (reg_wr && off == 8'd2) dst[7:0] <= io.cpu_din;
        if (reg_wr && off == 8'd3) dst[15:8] <= io.cpu_din;
        if (reg_wr && off == 8'd4) len <= io.cpu_din;
        if (ctrl_wr && io.cpu_din[0] && len != 8'd0) state <= READ;
      end else if (state == READ) begin
        if (abort_now) state <= IDLE;
        else if (dma_gnt) begin
          state <= WRITE;
          src <= src + 16'd1;
          cap <= 1'b1;
        end
      end else if (dma_gnt) begin
        dst <= dst + 16'd1;
        len <= len - 8'd1;
        if (len == 8'd1) begin
          state <= IDLE;
          done <= 1'b1;
        end else state <= abort_now ? IDLE : READ;
      end else if (abort_now) abort_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed scenarios with a bus-write scoreboard against a behavioural memory
module tb_dma_arbiter;
  localparam logic [7:0] DA = 8'h0C;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dma_arbiter_if io();
  dma_arbiter #(.DMA_ADDRESS(DA)) dut (.clk(clk), .rst(rst), .io(io.slave));
  logic [7:0] mem [0:65535];
  logic pl_we = 1'b0;
  logic [15:0] pl_a = '0;
  logic [7:0] pl_d = '0;
  logic [23:0] wq [$];
  int compared = 0;
  int mismatched = 0;
  // read data appears one cycle after the strobe; otherwise garbage so stale data is visible
  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    if (io.bus_w_en) mem[io.bus_address] <= io.bus_din;
    io.bus_dout <= io.bus_r_en ? mem[io.bus_address] : 8'hEE;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    logic [23:0] e;
    @(negedge clk);
    if (io.bus_w_en === 1'b1) begin
      chk("bus_write_expected", (wq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("bus_write", {8'h0, io.bus_address, io.bus_din}, {8'h0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_a = a;
    pl_d = d;
    pl_we = 1'b1;
    tick;
    pl_we = 1'b0;
  endtask
  task automatic wreg(input logic [2:0] o, input logic [7:0] d);
    io.cpu_address = {8'h10, DA + 8'(o)};
    io.cpu_din = d;
    io.cpu_w_en = 1'b1;
    tick;
    io.cpu_w_en = 1'b0;
  endtask
  task automatic rchk(input string tag, input logic [2:0] o, input logic [7:0] exp);
    io.cpu_address = {8'h10, DA + 8'(o)};
    io.cpu_r_en = 1'b1;
    tick;
    io.cpu_r_en = 1'b0;
    chk(tag, 32'(io.cpu_dout), 32'(exp));
  endtask
  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
    wreg(0, s[7:0]);
    wreg(1, s[15:8]);
    wreg(2, d[7:0]);
    wreg(3, d[15:8]);
    wreg(4, n);
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (io.done_flag !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    chk(tag, 32'(io.done_flag), 32'd1);
  endtask
  task automatic clear_done;
    io.done_flag_clr = 1'b1;
    tick;
    io.done_flag_clr = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    io.cpu_address = '0;
    io.cpu_din = '0;
    io.cpu_w_en = 1'b0;
    io.cpu_r_en = 1'b0;
    io.done_flag_clr = 1'b0;
    tick;
    poke(16'h0010, 8'hAA);
    poke(16'h0011, 8'hBB);
    poke(16'h0012, 8'hCC);
    poke(16'h0013, 8'hDD);
    poke(16'h0020, 8'h77);
    poke(16'hFFFF, 8'h11);
    poke(16'h0000, 8'h22);
    poke(16'h0100, 8'h5A);
    chk("rst_bus_w_en", 32'(io.bus_w_en), 0);
    chk("rst_bus_r_en", 32'(io.bus_r_en), 0);
    chk("rst_bus_address", 32'(io.bus_address), 0);
    chk("rst_cpu_stall", 32'(io.cpu_stall), 0);
    chk("rst_done", 32'(io.done_flag), 0);
    rst = 1'b0;
    rchk("rst_ctrl", 5, 8'h00);
    rchk("rst_src_l", 0, 8'h00);
    // uncontested copy: done exactly 6 cycles after start
    wq.push_back(24'h2000AA);
    wq.push_back(24'h2001BB);
    wq.push_back(24'h2002CC);
    setup(16'h0010, 16'h2000, 8'd3);
    wreg(5, 8'h01);
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (i < 6) chk("t1_done_early", 32'(io.done_flag), 0);
    end
    chk("t1_done_at_6", 32'(io.done_flag), 1);
    rchk("t1_ctrl_idle_done", 5, 8'h02);
    chk("t1_vram0", 32'(mem[16'h2000]), 32'hAA);
    chk("t1_vram1", 32'(mem[16'h2001]), 32'hBB);
    chk("t1_vram2", 32'(mem[16'h2002]), 32'hCC);
    chk("t1_drained", wq.size(), 0);
    clear_done;
    // contention: CPU reads back-to-back, grants alternate starting with the DMA
    for (int i = 0; i < 4; i++) wq.push_back({16'h3000 + 16'(i), 8'hAA + 8'(i * 17)});
    setup(16'h0010, 16'h3000, 8'd4);
    wreg(5, 8'h01);
    io.cpu_address = 16'h0100;
    io.cpu_r_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("t2_stall", 32'(io.cpu_stall), 32'(i % 2));
      if (i >= 3 && i % 2 == 1) chk("t2_cpu_rdata", 32'(io.cpu_dout), 32'h5A);
      tick;
    end
    io.cpu_r_en = 1'b0;
    #1;
    chk("t2_cpu_rdata_last", 32'(io.cpu_dout), 32'h5A);
    wait_done("t2_done");
    chk("t2_drained", wq.size(), 0);
    clear_done;
    // CPU takes the write slot right after the DMA read; DMA must replay its buffer
    rst = 1'b1;
    tick;
    rst = 1'b0;
    wq.push_back(24'h020055);
    wq.push_back(24'h210077);
    setup(16'h0020, 16'h2100, 8'd1);
    wreg(5, 8'h01);
    io.cpu_address = 16'h0200;
    io.cpu_din = 8'h55;
    io.cpu_w_en = 1'b1;
    #1;
    chk("t3_stall_c1", 32'(io.cpu_stall), 1);
    tick;
    #1;
    chk("t3_stall_c2", 32'(io.cpu_stall), 0);
    tick;
    io.cpu_w_en = 1'b0;
    wait_done("t3_done");
    chk("t3_cpu_mem", 32'(mem[16'h0200]), 32'h55);
    chk("t3_dma_mem", 32'(mem[16'h2100]), 32'h77);
    chk("t3_drained", wq.size(), 0);
    clear_done;
    // SRC wrap and a SRC write while busy
    wq.push_back(24'h220011);
    wq.push_back(24'h220122);
    setup(16'hFFFF, 16'h2200, 8'd2);
    wreg(5, 8'h01);
    tick;
    wreg(0, 8'h55);
    wait_done("t4_done");
    rchk("t4_src_l", 0, 8'h01);
    rchk("t4_src_h", 1, 8'h00);
    rchk("t4_dst_l", 2, 8'h02);
    rchk("t4_len", 4, 8'h00);
    chk("t4_drained", wq.size(), 0);
    clear_done;
    wreg(4, 8'h00);
    wreg(5, 8'h01);
    for (int i = 0; i < 3; i++) begin
      chk("t4_len0_no_read", 32'(io.bus_r_en), 0);
      tick;
    end
    rchk("t4_len0_ctrl", 5, 8'h00);
    // abort in WRITE: exactly one more write
    wq.push_back(24'h2300AA);
    setup(16'h0010, 16'h2300, 8'd3);
    wreg(5, 8'h01);
    tick;
    wreg(5, 8'h02);
    for (int i = 0; i < 4; i++) tick;
    chk("t5_abort_done", 32'(io.done_flag), 0);
    rchk("t5_abort_ctrl", 5, 8'h00);
    rchk("t5_abort_dst_l", 2, 8'h01);
    rchk("t5_abort_len", 4, 8'h02);
    chk("t5_abort_drained", wq.size(), 0);
    // abort in READ: immediate, nothing written, SRC untouched
    wreg(5, 8'h01);
    wreg(5, 8'h02);
    for (int i = 0; i < 4; i++) tick;
    rchk("t5_abort_rd_src", 0, 8'h11);
    rchk("t5_abort_rd_ctrl", 5, 8'h00);
    // set beats clear in the completion cycle
    wq.push_back(24'h2400BB);
    setup(16'h0011, 16'h2400, 8'd1);
    wreg(5, 8'h01);
    tick;
    io.done_flag_clr = 1'b1;
    tick;
    io.done_flag_clr = 1'b0;
    chk("t6_set_wins", 32'(io.done_flag), 1);
    rchk("t6_ctrl_02", 5, 8'h02);
    clear_done;
    chk("t6_cleared", 32'(io.done_flag), 0);
    rchk("t6_ctrl_00", 5, 8'h00);
    chk("t6_drained", wq.size(), 0);
    // reset during the first WRITE: that write is the last bus activity
    wq.push_back(24'h2500AA);
    setup(16'h0010, 16'h2500, 8'd3);
    wreg(5, 8'h01);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("t5_rst_w_en", 32'(io.bus_w_en), 0);
    chk("t5_rst_r_en", 32'(io.bus_r_en), 0);
    chk("t5_rst_address", 32'(io.bus_address), 0);
    chk("t5_rst_stall", 32'(io.cpu_stall), 0);
    chk("t5_rst_done", 32'(io.done_flag), 0);
    for (int i = 0; i < 4; i++) tick;
    rchk("t5_rst_ctrl", 5, 8'h00);
    rchk("t5_rst_src_l", 0, 8'h00);
    chk("t5_rst_drained", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
Memory-to-memory DMA engine with a built-in two-requester bus arbiter, placed between the CPU data port and the memory-mapped interface bus.
- Copies LEN bytes from SRC to DST over the same bus the CPU uses: d_ram, IO space and VRAM, for example a d_ram-to-VRAM blit.
- Shares the bus with the CPU using per-cycle round-robin and stalls the CPU when it loses arbitration.
- Its own register file sits in IO space at 0x1000 + DMA_ADDRESS.

Parameters:
DMA_ADDRESS, 8'h0C, low byte of the register base; registers occupy base+0 to base+5 within page 0x10xx.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cpu_address  input  16  CPU bus address
cpu_din  input  8  CPU write data
cpu_w_en  input  1  CPU write strobe
cpu_r_en  input  1  CPU read strobe
cpu_dout  output  8  read data to CPU
cpu_stall  output  1  CPU request not granted this cycle; CPU holds its request
bus_address  output  16  address to the interface bus
bus_din  output  8  write data to the interface bus
bus_w_en  output  1  interface write strobe
bus_r_en  output  1  interface read strobe
bus_dout  input  8  interface read data, valid 1 cycle after bus_r_en
done_flag  output  1  transfer-complete interrupt flag
done_flag_clr  input  1  clears done_flag

Behaviour:
Registers (offset, name, meaning):
- 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN (1 to 255), 5 CTRL.
- CTRL write: bit0 = start, bit1 = abort.
- CTRL read: bit0 = busy, bit1 = done_flag, other bits 0.

Register access:
- Address decode: cpu_address[15:8] == 8'h10 and cpu_address[7:0] in DMA_ADDRESS to DMA_ADDRESS+5.
- A decoded access is handled internally and never forwarded to the bus; it never stalls.
- Writes to a register take effect on the clock edge.
- Reads return data on cpu_dout 1 cycle after r_en, matching the interface's read latency.
- cpu_dout selects register data when the previous cycle was a register read; otherwise it passes bus_dout.
- While busy, writes to SRC, DST and LEN are ignored. Reads of those registers return the live counters.

Reset:
- All registers 0, FSM in IDLE, done_flag = 0, busy = 0, last_grant = CPU.
- All bus strobes 0, bus_address = 0, cpu_stall = 0.
- Reset mid-transfer aborts immediately; there is no partial write after the reset edge.

FSM states: IDLE, READ, WRITE.
- IDLE: a CTRL write with bit0 = 1 and LEN != 0 moves to READ and sets busy. A start with LEN == 0 is ignored and done is not set.
- READ: DMA requests a read at SRC. When granted: go to WRITE, increment SRC by 1 (16-bit wrap, FFFF to 0000), and mark a capture for the next cycle.
- WRITE, first cycle after the granted read: bus_dout is captured into data_buf, and bus_din = bus_dout.
- WRITE, later cycles (the CPU won arbitration): bus_din = data_buf.
- WRITE, when granted: write to DST, increment DST (16-bit wrap), decrement LEN. If LEN becomes 0: go to IDLE, clear busy, set done_flag. Otherwise go to READ.
- Uncontested throughput: 2 cycles per byte.

Abort (CTRL bit1 written while busy):
- In READ: go to IDLE at once.
- In WRITE: finish the pending write, then go to IDLE.
- done_flag is not set; the counters keep their current values.

Arbitration:
- CPU request = (cpu_w_en | cpu_r_en) and the address is not a DMA register. DMA request = state is READ or WRITE.
- Only one requester: it is granted.
- Both request: grant goes to the requester that is not last_grant. last_grant updates only on contested cycles.
- cpu_stall = CPU request and not CPU grant, combinational.
- Bus outputs mux from the granted requester. With no grant, all strobes are 0.

done_flag:
- Set on completion; cleared by done_flag_clr. Set has priority over a clear in the same cycle.

Test Plan:
1. Uncontested copy: write SRC=0x0010, DST=0x2000, LEN=3, d_ram[0x10..0x12] = AA/BB/CC, CTRL=1.
   -> VRAM 0x2000..0x2002 = AA/BB/CC. done_flag rises exactly 6 cycles after start; busy then reads 0.
2. Contention: CPU issues back-to-back reads of 0x0100 during a LEN=4 transfer.
   -> Grants alternate CPU/DMA; cpu_stall is high on alternate cycles; DMA data is correct; CPU read data is correct.
3. CPU wins the WRITE slot: force a contested cycle right after a DMA read, with the CPU writing 0x55 to 0x0200.
   -> The DMA writes the data_buf value, not the CPU's data. Both writes land correctly.
4. Boundaries: SRC=0xFFFF, LEN=2 -> the second read is from 0x0000. A start with LEN=0 -> busy stays 0, no bus traffic. A SRC write while busy -> ignored.
5. Abort and reset: abort while in WRITE -> exactly one further write, then IDLE with done_flag = 0. Assert rst mid-transfer -> all outputs take their reset values on the next edge.
6. Flag race: done_flag_clr asserted in the same cycle as completion -> done_flag = 1. done_flag_clr the next cycle -> done_flag = 0. A CTRL read returns 0x02 and then 0x00.
